// File: rtl/stage_1_if.sv
// Instruction-fetch stage: owns the PC, issues reads to the synchronous inst SRAM,
// and hands {inst, pc} to decode under allow_2 back-pressure and branch redirects.
module stage_1_if #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        allow_2,
  output logic        valid_1,
  output logic [63:0] stage_1_to_2,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  logic        pre_valid_q;
  logic        fs_valid_q;
  logic [31:0] fs_pc_q;
  logic        br_pend_q;
  logic [31:0] br_pend_target_q;
  logic        ibuf_valid_q;
  logic [31:0] ibuf_q;

  logic        fs_allowin;
  logic        fetch_go;
  logic        ibuf_load;
  logic [31:0] nextpc;
  logic [31:0] inst;
  logic [31:0] inst_out;

  assign fs_allowin = ~fs_valid_q | allow_2;
  assign fetch_go   = pre_valid_q & fs_allowin;
  assign ibuf_load  = fs_valid_q & ~allow_2 & ~ibuf_valid_q;

  always_comb begin
    nextpc = fs_pc_q + 32'd4;
    if (br_taken) begin
      nextpc = br_target;
    end else if (br_pend_q) begin
      nextpc = br_pend_target_q;
    end
  end

  // The SRAM word is only valid the cycle after the request, so a stalled
  // instruction is parked in ibuf to stay stable for decode.
  assign inst     = ibuf_valid_q ? ibuf_q : inst_sram_rdata;
  assign inst_out = fs_valid_q ? inst : 32'b0;

  assign valid_1         = fs_valid_q & ~br_taken & ~br_pend_q;
  assign stage_1_to_2    = resetn ? {inst_out, fs_pc_q} : 64'b0;
  assign inst_sram_en    = fetch_go;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_we    = 4'b0;
  assign inst_sram_wdata = 32'b0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pre_valid_q      <= 1'b0;
      fs_valid_q       <= 1'b0;
      fs_pc_q          <= RESET_PC - 32'd4;
      br_pend_q        <= 1'b0;
      br_pend_target_q <= 32'b0;
      ibuf_valid_q     <= 1'b0;
      ibuf_q           <= 32'b0;
    end else begin
      pre_valid_q <= 1'b1;
      // fs_pc only advances once a request has actually been issued, so the
      // first fetched PC is RESET_PC.
      if (fetch_go) begin
        fs_pc_q      <= nextpc;
        fs_valid_q   <= 1'b1;
        br_pend_q    <= 1'b0;
        ibuf_valid_q <= 1'b0;
      end else if (!fs_allowin && br_taken) begin
        br_pend_q        <= 1'b1;
        br_pend_target_q <= br_target;
      end
      if (ibuf_load) begin
        ibuf_q       <= inst_sram_rdata;
        ibuf_valid_q <= 1'b1;
      end
    end
  end

endmodule
